main_ctrl_fsm: RTL and testbench

Multicycle main controller for the MIPS core. It is a Moore state machine that sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each state drives the datapath's mux selects, write enables and the 2-bit ALUOp consumed by the ALU decoder. It sits between the instruction register's opcode field and the shared single-ALU datapath.

---
 rtl/main_ctrl_fsm.sv | 180 ++++++++++++++++++
 tb/tb_main_ctrl_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/main_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// main_ctrl_fsm
// Multicycle MIPS main controller. A Moore machine that walks one instruction
// through FETCH / DECODE / execute / memory / writeback, driving the datapath
// mux selects, write enables and the ALUOp code for the ALU decoder.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high
//   Op        in   opcode IR[31:26], sampled only when leaving DECODE
//   Zero      in   ALU zero flag, qualifies PCEn in BRANCH
//   IorD      out  memory address select (0=PC, 1=ALUOut)
//   ALUSrcA   out  ALU A select (0=PC, 1=reg A)
//   ALUSrcB   out  ALU B select (00=B, 01=4, 10=SignImm, 11=SignImm<<2)
//   ALUOp     out  ALU decoder code (00 add, 01 sub, 10 funct)
//   PCSrc     out  next-PC select (00=ALUResult, 01=ALUOut, 10=jump)
//   RegDst    out  destination register (0=rt, 1=rd)
//   MemtoReg  out  writeback data (0=ALUOut, 1=memory data)
//   IRWrite, PCWrite, RegWrite, MemWrite, Branch   out  enables
//   PCEn      out  PCWrite | (Branch & Zero)
//   Illegal   out  unsupported opcode seen in DECODE
// -----------------------------------------------------------------------------
module main_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic       PCEn,
  output logic       Illegal
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
  } ctrl_t;

  // Control word for each state; anything not set stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR,
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BRANCH:  begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // lw/sw share MEMADR; the sw/lw choice is remembered from DECODE so that
  // Op is only ever looked at on the DECODE exit edge.
  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic is_sw);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:   n = S_DECODE;
      S_DECODE:
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYP:      n = S_EXECUTE;
          OP_BEQ:       n = S_BRANCH;
          OP_ADDI:      n = S_ADDIEX;
          OP_J:         n = S_JUMP;
          default:      n = S_FETCH;
        endcase
      S_MEMADR:  n = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   n = S_MEMWB;
      S_EXECUTE: n = S_ALUWB;
      S_ADDIEX:  n = S_ADDIWB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  state_t r_state;
  ctrl_t  r_ctrl;
  logic   r_is_sw;
  logic   r_in_decode;
  state_t w_next;
  logic   w_legal_op;
  logic   w_run;

  assign w_next     = next_state(r_state, Op, r_is_sw);
  assign w_legal_op = (Op == OP_LW) || (Op == OP_SW) || (Op == OP_RTYP) ||
                      (Op == OP_BEQ) || (Op == OP_ADDI) || (Op == OP_J);

  // NOTE: state and registered outputs use <= so every register in this block
  // samples the pre-edge values; a blocking = would leak the new state into the
  // output decode within the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_ctrl      <= state_ctrl(S_FETCH);
      r_is_sw     <= 1'b0;
      r_in_decode <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ctrl      <= state_ctrl(w_next);
      r_in_decode <= (w_next == S_DECODE);
      if (r_state == S_DECODE) r_is_sw <= (Op == OP_SW);
    end
  end

  // NOTE: enables are gated by reset combinationally so they are 0 for the
  // whole reset cycle, including the very first one before any edge has
  // loaded the registers.
  assign w_run = ~reset;

  assign IorD     = r_ctrl.iord;
  assign ALUSrcA  = r_ctrl.alusrca;
  assign ALUSrcB  = r_ctrl.alusrcb;
  assign ALUOp    = r_ctrl.aluop;
  assign PCSrc    = r_ctrl.pcsrc;
  assign RegDst   = r_ctrl.regdst;
  assign MemtoReg = r_ctrl.memtoreg;
  assign IRWrite  = w_run & r_ctrl.irwrite;
  assign PCWrite  = w_run & r_ctrl.pcwrite;
  assign RegWrite = w_run & r_ctrl.regwrite;
  assign MemWrite = w_run & r_ctrl.memwrite;
  assign Branch   = w_run & r_ctrl.branch;
  assign PCEn     = w_run & (r_ctrl.pcwrite | (r_ctrl.branch & Zero));
  assign Illegal  = w_run & r_in_decode & ~w_legal_op;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_ctrl_fsm
// Directed, table-driven bench for main_ctrl_fsm. Each table row is one clock
// cycle: inputs driven after the falling edge, outputs compared before the
// next rising edge. A second part measures FETCH-to-FETCH cycle counts.
// -----------------------------------------------------------------------------
module tb_main_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       IorD, ALUSrcA, RegDst, MemtoReg;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, Branch, PCEn, Illegal;

  main_ctrl_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .Op       (Op),
    .Zero     (Zero),
    .IorD     (IorD),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSrc    (PCSrc),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .PCEn     (PCEn),
    .Illegal  (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010,
                         BAD = 6'b111111;

  // Output word: {IorD, ALUSrcA, ALUSrcB, ALUOp, PCSrc, RegDst, MemtoReg,
  //               IRWrite, PCWrite, RegWrite, MemWrite, Branch, PCEn, Illegal}
  localparam logic [16:0] E_FETCH    = 17'b0_0_01_00_00_0_0_1_1_0_0_0_1_0;
  localparam logic [16:0] E_FETCH_R  = 17'b0_0_01_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_DECODE   = 17'b0_0_11_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_DECODE_I = 17'b0_0_11_00_00_0_0_0_0_0_0_0_0_1;
  localparam logic [16:0] E_MEMADR   = 17'b0_1_10_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_MEMRD    = 17'b1_0_00_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_MEMWB    = 17'b0_0_00_00_00_0_1_0_0_1_0_0_0_0;
  localparam logic [16:0] E_MEMWB_R  = 17'b0_0_00_00_00_0_1_0_0_0_0_0_0_0;
  localparam logic [16:0] E_MEMWR    = 17'b1_0_00_00_00_0_0_0_0_0_1_0_0_0;
  localparam logic [16:0] E_EXEC     = 17'b0_1_00_10_00_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] E_ALUWB    = 17'b0_0_00_00_00_1_0_0_0_1_0_0_0_0;
  localparam logic [16:0] E_BR_Z1    = 17'b0_1_00_01_01_0_0_0_0_0_0_1_1_0;
  localparam logic [16:0] E_BR_Z0    = 17'b0_1_00_01_01_0_0_0_0_0_0_1_0_0;
  localparam logic [16:0] E_ADDIWB   = 17'b0_0_00_00_00_0_0_0_0_1_0_0_0_0;
  localparam logic [16:0] E_JUMP     = 17'b0_0_00_00_10_0_0_0_1_0_0_0_1_0;
  localparam logic [16:0] M_ALL      = 17'h1FFFF;
  localparam logic [16:0] M_EN       = 17'h0007F;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic [16:0] exp;
    logic [16:0] mask;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [16:0] outs();
    return {IorD, ALUSrcA, ALUSrcB, ALUOp, PCSrc, RegDst, MemtoReg,
            IRWrite, PCWrite, RegWrite, MemWrite, Branch, PCEn, Illegal};
  endfunction

  task automatic check(input string name, input logic [16:0] got,
                       input logic [16:0] exp, input logic [16:0] mask);
    n_checks++;
    if ((got & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (mask %b)", name, got, exp, mask);
    end
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic zero,
                     input logic [16:0] exp, input logic [16:0] mask = M_ALL);
    vec_t v;
    v.rst = rst; v.op = op; v.zero = zero; v.exp = exp; v.mask = mask;
    vecs.push_back(v);
  endtask

  // Counts cycles from the current FETCH until IRWrite marks the next FETCH.
  task automatic measure(input string name, input logic [5:0] op, input int exp_n);
    int n;
    Op = op;
    n  = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!IRWrite && n < 10);
    n_checks++;
    if (n != exp_n) begin
      n_fail++;
      $display("FAIL %s: took %0d cycles, expected %0d", name, n, exp_n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; Op = LW; Zero = 1'b0;

    // reset held two cycles, then lw
    add(1, LW, 0, 17'h0, M_EN);      // 0  before first edge: enables only
    add(1, LW, 0, E_FETCH_R);        // 1  FETCH, enables forced off
    add(0, LW, 0, E_FETCH);          // 2
    add(0, LW, 0, E_DECODE);         // 3
    add(0, SW, 0, E_MEMADR);         // 4  Op change ignored
    add(0, SW, 0, E_MEMRD);          // 5
    add(0, SW, 0, E_MEMWB);          // 6
    // R-type
    add(0, RT, 0, E_FETCH);          // 7
    add(0, RT, 0, E_DECODE);         // 8
    add(0, RT, 0, E_EXEC);           // 9
    add(0, RT, 0, E_ALUWB);          // 10
    // beq taken, then not taken
    add(0, BQ, 0, E_FETCH);          // 11
    add(0, BQ, 0, E_DECODE);         // 12
    add(0, BQ, 1, E_BR_Z1);          // 13
    add(0, BQ, 1, E_FETCH);          // 14
    add(0, BQ, 0, E_DECODE);         // 15
    add(0, BQ, 0, E_BR_Z0);          // 16
    // sw, addi, j back to back
    add(0, SW, 0, E_FETCH);          // 17
    add(0, SW, 0, E_DECODE);         // 18
    add(0, LW, 0, E_MEMADR);         // 19 Op change must not turn it into lw
    add(0, LW, 0, E_MEMWR);          // 20
    add(0, AI, 0, E_FETCH);          // 21
    add(0, AI, 0, E_DECODE);         // 22
    add(0, AI, 0, E_MEMADR);         // 23 ADDIEX
    add(0, AI, 0, E_ADDIWB);         // 24
    add(0, JP, 0, E_FETCH);          // 25
    add(0, JP, 0, E_DECODE);         // 26
    add(0, JP, 0, E_JUMP);           // 27
    // illegal opcode
    add(0, BAD, 0, E_FETCH);         // 28
    add(0, BAD, 0, E_DECODE_I);      // 29
    add(0, BAD, 0, E_FETCH);         // 30 Illegal only in DECODE
    // Zero outside BRANCH has no effect on PCEn
    add(0, RT, 1, E_DECODE);         // 31
    add(0, RT, 1, E_EXEC);           // 32
    add(0, RT, 1, E_ALUWB);          // 33
    // reset during MEMRD of lw
    add(0, LW, 0, E_FETCH);          // 34
    add(0, LW, 0, E_DECODE);         // 35
    add(0, LW, 0, E_MEMADR);         // 36
    add(1, LW, 0, E_MEMRD);          // 37
    add(0, LW, 0, E_FETCH);          // 38 MEMWB skipped
    // reset during MEMWB suppresses RegWrite
    add(0, LW, 0, E_DECODE);         // 39
    add(0, LW, 0, E_MEMADR);         // 40
    add(0, LW, 0, E_MEMRD);          // 41
    add(1, LW, 0, E_MEMWB_R);        // 42
    add(0, LW, 0, E_FETCH);          // 43
    // reset in DECODE with illegal Op: Illegal forced off
    add(1, BAD, 0, E_DECODE);        // 44
    add(0, RT, 0, E_FETCH);          // 45

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      Op    = vecs[i].op;
      Zero  = vecs[i].zero;
      #2;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp, vecs[i].mask);
    end

    // FETCH-to-FETCH latencies, starting in FETCH
    Zero = 1'b0;
    measure("len_lw",   LW,  5);
    measure("len_sw",   SW,  4);
    measure("len_rtyp", RT,  4);
    measure("len_addi", AI,  4);
    measure("len_beq",  BQ,  3);
    measure("len_j",    JP,  3);
    measure("len_bad",  BAD, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
